load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-side responder for the MemRead/MemWrite/Funct3 commands issued by the decoder; turns them into one bus transaction per access.
- Generates byte enables and lane-shifted store data, and extracts sign- or zero-extended load data.
- Stalls the pipeline until the access completes; flags misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT_R before the access is aborted (1..65535)

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  reset, asynchronous, active-low
MemRead_in  input  1  load command from decoder
MemWrite_in  input  1  store command from decoder
Funct3_in  input  3  access size/sign (RV32I funct3)
Addr_in  input  32  byte address from ALU
StoreData_in  input  32  rs2 value
Stall_out  output  1  hold pipeline
LoadData_out  output  32  extended load result
LoadValid_out  output  1  LoadData_out valid (1-cycle pulse)
AccessErr_out  output  1  error pulse (misaligned / illegal funct3 / timeout)
BusReq_out  output  1  bus request valid
BusWe_out  output  1  1=write
BusAddr_out  output  32  word address {Addr[31:2],2'b00}
BusWdata_out  output  32  lane-shifted write data
BusBe_out  output  4  byte enables
BusGnt_in  input  1  bus accepts request this cycle
BusRvalid_in  input  1  read data valid
BusRdata_in  input  32  read data

Behaviour:
- Reset (async, rst_n_in=0):
  - state IDLE, timeout counter 0.
  - All outputs 0: LoadData_out=0, BusBe_out=0.
  - Asserting reset mid-transaction drops BusReq_out immediately; any response arriving afterwards is ignored.
- Command rules:
  - MemWrite_in=1 takes priority when both commands are high.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Misalignment: halfword with Addr[0]=1; word with Addr[1:0]!=0.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - Command present and legal/aligned: register address, BE, WDATA, funct3 and we, then go to REQ.
  - Command illegal or misaligned: AccessErr_out=1 for exactly one cycle, no bus activity, stay in IDLE, Stall_out=0.
- REQ:
  - BusReq_out=1; address, BE, WDATA and WE are held stable until BusGnt_in=1.
  - On grant: store goes to DONE, load goes to WAIT_R. BusReq_out drops the cycle after grant.
- WAIT_R: on BusRvalid_in=1, register the extracted data and go to DONE. BusRvalid_in seen outside WAIT_R is ignored.
- DONE (one cycle):
  - Loads: LoadValid_out=1.
  - Errors: AccessErr_out=1.
  - Next state is IDLE. Commands present during DONE are ignored.
- Stall_out is combinational: (IDLE & command & legal & aligned) | REQ | WAIT_R. Minimum latency is IDLE to REQ to DONE, 3 cycles with immediate grant.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT_R.
  - On reaching TIMEOUT_CYCLES: go to DONE with AccessErr_out=1, LoadValid_out=0, LoadData_out=0.
  - If grant or rvalid arrives in the same cycle as the timeout, the grant/rvalid wins.
- Store lanes:
  - SB: BE=4'b0001<<Addr[1:0], WDATA={4{byte}}.
  - SH: BE=4'b0011<<{Addr[1],1'b0}, WDATA={2{half}}.
  - SW: BE=4'b1111.
- Load extraction: select byte/half by Addr[1:0] from BusRdata_in, then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes the word through.
- LoadData_out keeps its value until the next load completes.

Test Plan:
- LW at 0x00000104 with immediate grant and rvalid 2 cycles later, BusRdata=0xDEADBEEF → BusAddr=0x104, BE=1111, Stall high 4 cycles, LoadValid pulse, LoadData=0xDEADBEEF.
- LB and LBU at 0x103 with rdata=0x80FF1234 → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x22, data=0x0000ABCD, grant delayed 5 cycles → BusReq high for 6 cycles with stable outputs, BE=1100, WDATA=0xABCDABCD, BusWe=1, no LoadValid.
- LW at 0x101 and SH at 0x003, each as a separate command → AccessErr pulse of 1 cycle each, BusReq never asserted, Stall stays 0.
- Load with BusGnt tied 0, TIMEOUT_CYCLES=8 → AccessErr pulse after 8 cycles in REQ, LoadData=0, return to IDLE.
- Reset asserted while in WAIT_R, then rvalid pulsed → all outputs 0 immediately, no LoadValid; a following SW at 0x10 completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - Load/store bus responder: lane steering, extension, stall and error reporting
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  Funct3_in,
    input  logic [31:0] Addr_in,
    input  logic [31:0] StoreData_in,
    output logic        Stall_out,
    output logic [31:0] LoadData_out,
    output logic        LoadValid_out,
    output logic        AccessErr_out,
    output logic        BusReq_out,
    output logic        BusWe_out,
    output logic [31:0] BusAddr_out,
    output logic [31:0] BusWdata_out,
    output logic [3:0]  BusBe_out,
    input  logic        BusGnt_in,
    input  logic        BusRvalid_in,
    input  logic [31:0] BusRdata_in
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t      state;
    state_t      stateNext;

    logic [31:0] addrReg;
    logic [3:0]  beReg;
    logic [31:0] wdataReg;
    logic [2:0]  f3Reg;
    logic        weReg;
    logic        tmoErrReg;
    logic [15:0] cycleCnt;
    logic [31:0] loadDataReg;
    logic        idleErrReg;

    logic        cmdPresent;
    logic        funct3Legal;
    logic        misaligned;
    logic        acceptCmd;
    logic        rejectCmd;
    logic        timeoutNow;
    logic        timeoutHit;
    logic [3:0]  beNew;
    logic [31:0] wdataNew;
    logic [7:0]  rdByte;
    logic [15:0] rdHalf;
    logic [31:0] loadExt;

    // Command decode; a store wins when both commands are raised together
    always_comb begin
        cmdPresent  = MemRead_in | MemWrite_in;
        funct3Legal = 1'b0;
        if (MemWrite_in) begin
            funct3Legal = (Funct3_in == 3'b000) || (Funct3_in == 3'b001) || (Funct3_in == 3'b010);
        end else begin
            funct3Legal = (Funct3_in == 3'b000) || (Funct3_in == 3'b001) || (Funct3_in == 3'b010) ||
                          (Funct3_in == 3'b100) || (Funct3_in == 3'b101);
        end
        misaligned = ((Funct3_in[1:0] == 2'b01) && Addr_in[0]) ||
                     ((Funct3_in[1:0] == 2'b10) && (Addr_in[1:0] != 2'b00));
        acceptCmd  = (state == IDLE) && cmdPresent && funct3Legal && !misaligned;
        rejectCmd  = (state == IDLE) && cmdPresent && !(funct3Legal && !misaligned);
    end

    always_comb begin
        beNew    = 4'b1111;
        wdataNew = StoreData_in;
        case (Funct3_in[1:0])
            2'b00: begin
                beNew    = 4'b0001 << Addr_in[1:0];
                wdataNew = {4{StoreData_in[7:0]}};
            end
            2'b01: begin
                beNew    = 4'b0011 << {Addr_in[1], 1'b0};
                wdataNew = {2{StoreData_in[15:0]}};
            end
            default: begin
                beNew    = 4'b1111;
                wdataNew = StoreData_in;
            end
        endcase
    end

    always_comb begin
        rdByte  = BusRdata_in[{addrReg[1:0], 3'b000} +: 8];
        rdHalf  = BusRdata_in[{addrReg[1], 4'b0000} +: 16];
        case (f3Reg)
            3'b000:  loadExt = {{24{rdByte[7]}}, rdByte};
            3'b001:  loadExt = {{16{rdHalf[15]}}, rdHalf};
            3'b100:  loadExt = {24'h000000, rdByte};
            3'b101:  loadExt = {16'h0000, rdHalf};
            default: loadExt = BusRdata_in;
        endcase
    end

    // A grant or rvalid in the timeout cycle still completes the access normally
    always_comb begin
        stateNext  = state;
        timeoutNow = (cycleCnt == 16'(TIMEOUT_CYCLES - 1));
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (acceptCmd) stateNext = REQ;
            end
            REQ: begin
                if (BusGnt_in) begin
                    stateNext = weReg ? DONE : WAIT_R;
                end else if (timeoutNow) begin
                    stateNext  = DONE;
                    timeoutHit = 1'b1;
                end
            end
            WAIT_R: begin
                if (BusRvalid_in) begin
                    stateNext = DONE;
                end else if (timeoutNow) begin
                    stateNext  = DONE;
                    timeoutHit = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            addrReg     <= 32'h0;
            beReg       <= 4'h0;
            wdataReg    <= 32'h0;
            f3Reg       <= 3'h0;
            weReg       <= 1'b0;
            tmoErrReg   <= 1'b0;
            cycleCnt    <= 16'h0;
            loadDataReg <= 32'h0;
            idleErrReg  <= 1'b0;
        end else begin
            state      <= stateNext;
            idleErrReg <= rejectCmd;
            if (acceptCmd) begin
                addrReg   <= Addr_in;
                beReg     <= beNew;
                wdataReg  <= wdataNew;
                f3Reg     <= Funct3_in;
                weReg     <= MemWrite_in;
                tmoErrReg <= 1'b0;
                cycleCnt  <= 16'h0;
            end else if ((state == REQ) || (state == WAIT_R)) begin
                cycleCnt <= cycleCnt + 16'd1;
            end
            if (timeoutHit) tmoErrReg <= 1'b1;
            // A timed-out store leaves the last load result untouched
            if ((state == WAIT_R) && BusRvalid_in) begin
                loadDataReg <= loadExt;
            end else if (timeoutHit && !weReg) begin
                loadDataReg <= 32'h0;
            end
        end
    end

    always_comb begin
        Stall_out     = acceptCmd || (state == REQ) || (state == WAIT_R);
        BusReq_out    = (state == REQ);
        BusWe_out     = (state == REQ) && weReg;
        BusAddr_out   = (state == REQ) ? {addrReg[31:2], 2'b00} : 32'h0;
        BusBe_out     = (state == REQ) ? beReg : 4'h0;
        BusWdata_out  = (state == REQ) ? wdataReg : 32'h0;
        LoadValid_out = (state == DONE) && !weReg && !tmoErrReg;
        AccessErr_out = idleErrReg || ((state == DONE) && tmoErrReg);
        LoadData_out  = loadDataReg;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - Randomized transaction-level check of load_store_unit
module tb_load_store_unit;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [2:0]  funct3 = 3'h0;
    logic [31:0] addr = 32'h0, storeData = 32'h0;
    logic        stall, loadValid, accessErr, busReq, busWe;
    logic [31:0] loadData, busAddr, busWdata;
    logic [3:0]  busBe;
    logic        busGnt = 1'b0, busRvalid = 1'b0;
    logic [31:0] busRdata = 32'h0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk), .rst_n_in(rstN),
        .MemRead_in(memRead), .MemWrite_in(memWrite), .Funct3_in(funct3),
        .Addr_in(addr), .StoreData_in(storeData),
        .Stall_out(stall), .LoadData_out(loadData), .LoadValid_out(loadValid),
        .AccessErr_out(accessErr), .BusReq_out(busReq), .BusWe_out(busWe),
        .BusAddr_out(busAddr), .BusWdata_out(busWdata), .BusBe_out(busBe),
        .BusGnt_in(busGnt), .BusRvalid_in(busRvalid), .BusRdata_in(busRdata)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    bit chkEn = 1'b1;
    bit expStall = 0, expReq = 0, expLv = 0, expErr = 0, expWe = 0;
    logic [31:0] expAddr = 0, expWdata = 0, lastLoad = 0;
    logic [3:0]  expBe = 0;
    int stallCnt = 0, reqCnt = 0, lvCnt = 0, errCnt = 0;
    logic [31:0] seenAddr = 0, seenWdata = 0;
    logic [3:0]  seenBe = 0;
    logic        seenWe = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit isLegal(input bit w, input logic [2:0] f);
        if (w) return f <= 3'd2;
        return (f <= 3'd2) || (f == 3'd4) || (f == 3'd5);
    endfunction

    function automatic int sizeOf(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic bit isAligned(input logic [2:0] f, input logic [31:0] a);
        return (a % sizeOf(f)) == 0;
    endfunction

    function automatic logic [3:0] laneMask(input logic [2:0] f, input logic [31:0] a);
        logic [3:0] m = 0;
        int off = int'(a[1:0]);
        for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + sizeOf(f));
        return m;
    endfunction

    function automatic logic [31:0] laneData(input logic [2:0] f, input logic [31:0] d);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sizeOf(f)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
        longint v = longint'(w >> (8 * int'(a[1:0])));
        longint span = longint'(1) << (8 * sizeOf(f));
        if (sizeOf(f) == 4) return w;
        v = v % span;
        if (!f[2] && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    always @(negedge clk) begin
        if (chkEn) begin
            chk("stall", 32'(stall), 32'(expStall));
            chk("busReq", 32'(busReq), 32'(expReq));
            chk("loadValid", 32'(loadValid), 32'(expLv));
            chk("accessErr", 32'(accessErr), 32'(expErr));
            chk("loadData", loadData, lastLoad);
            if (expReq) begin
                chk("busWe", 32'(busWe), 32'(expWe));
                chk("busAddr", busAddr, expAddr);
                chk("busBe", 32'(busBe), 32'(expBe));
                if (expWe) chk("busWdata", busWdata, expWdata);
                seenAddr = busAddr; seenBe = busBe; seenWdata = busWdata; seenWe = busWe;
            end
            if (stall) stallCnt++;
            if (busReq) reqCnt++;
            if (loadValid) lvCnt++;
            if (accessErr) errCnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        memRead = 0; memWrite = 0; funct3 = 0;
        addr = $urandom; storeData = $urandom;
        busGnt = 0; busRvalid = 0; busRdata = $urandom;
        expStall = 0; expReq = 0; expLv = 0; expErr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            busRvalid = $urandom % 2;
        end
    endtask

    task automatic clearCounts();
        stallCnt = 0; reqCnt = 0; lvCnt = 0; errCnt = 0;
    endtask

    task automatic settle();
        step();
        @(negedge clk);
        #1;
    endtask

    // gd: REQ cycles before grant; rd: cycles from grant to rvalid (>=1)
    task automatic access(input bit w, input bit r, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] sd, input int gd, input int rd, input logic [31:0] rdat);
        bit isLd = r && !w;
        bit err = 0;
        int c = 0;
        logic [31:0] data = 0;
        step();
        memWrite = w; memRead = r; funct3 = f; addr = a; storeData = sd;
        busRvalid = $urandom % 2;
        if (!isLegal(w, f) || !isAligned(f, a)) begin
            step();
            expErr = 1;
            return;
        end
        expStall = 1;
        forever begin
            step();
            busRvalid = $urandom % 2;
            expStall = 1; expReq = 1; expWe = w;
            expAddr = {a[31:2], 2'b00}; expBe = laneMask(f, a); expWdata = laneData(f, sd);
            if (c == gd) begin busGnt = 1; c++; break; end
            if (c == TMO - 1) begin err = 1; c++; break; end
            c++;
        end
        if (!err && isLd) begin
            for (int j = 0; ; j++) begin
                step();
                expStall = 1;
                if (j == rd - 1) begin
                    busRvalid = 1; busRdata = rdat; data = extract(f, a, rdat);
                    break;
                end
                if (c == TMO - 1) begin err = 1; break; end
                c++;
            end
        end
        step();
        busRvalid = $urandom % 2;
        if ($urandom % 2) begin
            memWrite = $urandom % 2; memRead = 1; funct3 = $urandom; addr = $urandom & 32'hFFFF_FFFC;
        end
        expLv = isLd && !err;
        expErr = err;
        if (isLd) lastLoad = err ? 32'h0 : data;
    endtask

    initial begin
        #2;
        chk("reset busBe", 32'(busBe), 32'h0);
        chk("reset loadData", loadData, 32'h0);
        chk("reset busReq", 32'(busReq), 32'h0);
        idle(2);
        rstN = 1;
        idle(2);

        clearCounts();
        access(0, 1, 3'b010, 32'h104, 0, 0, 2, 32'hDEADBEEF);
        settle();
        chk("lw stallCycles", 32'(stallCnt), 32'd4);
        chk("lw data", loadData, 32'hDEADBEEF);
        chk("lw addr", seenAddr, 32'h104);
        chk("lw be", 32'(seenBe), 32'hF);
        chk("lw pulses", 32'(lvCnt), 32'd1);

        access(0, 1, 3'b000, 32'h103, 0, 1, 1, 32'h80FF1234);
        settle();
        chk("lb data", loadData, 32'hFFFFFF80);
        access(0, 1, 3'b100, 32'h103, 0, 0, 3, 32'h80FF1234);
        settle();
        chk("lbu data", loadData, 32'h00000080);

        clearCounts();
        access(1, 0, 3'b001, 32'h22, 32'h0000ABCD, 5, 1, 0);
        settle();
        chk("sh reqCycles", 32'(reqCnt), 32'd6);
        chk("sh be", 32'(seenBe), 32'hC);
        chk("sh wdata", seenWdata, 32'hABCDABCD);
        chk("sh we", 32'(seenWe), 32'h1);
        chk("sh noLoadValid", 32'(lvCnt), 32'd0);

        clearCounts();
        access(0, 1, 3'b010, 32'h101, 0, 0, 1, 0);
        access(1, 0, 3'b001, 32'h003, 32'h1234, 0, 1, 0);
        settle();
        chk("misalign errPulses", 32'(errCnt), 32'd2);
        chk("misalign noReq", 32'(reqCnt), 32'd0);
        chk("misalign noStall", 32'(stallCnt), 32'd0);

        access(0, 1, 3'b010, 32'h200, 0, 0, 1, 32'h5A5A1234);
        clearCounts();
        access(0, 1, 3'b010, 32'h204, 0, 100, 1, 0);
        settle();
        chk("timeout reqCycles", 32'(reqCnt), 32'd8);
        chk("timeout errPulses", 32'(errCnt), 32'd1);
        chk("timeout loadData", loadData, 32'h0);

        clearCounts();
        access(1, 0, 3'b010, 32'h300, 32'h11223344, TMO - 1, 1, 0);
        access(0, 1, 3'b101, 32'h302, 0, 0, TMO - 1, 32'h8001F00D);
        settle();
        chk("edge grantWins noErr", 32'(errCnt), 32'd0);
        chk("edge rvalidWins data", loadData, 32'h00008001);

        step();
        memRead = 1; funct3 = 3'b010; addr = 32'h40; expStall = 1;
        step();
        busGnt = 1; expStall = 1; expReq = 1; expWe = 0; expAddr = 32'h40; expBe = 4'hF;
        step();
        expStall = 1;
        #2;
        rstN = 0;
        expStall = 0; lastLoad = 0;
        #1;
        chk("rst stall", 32'(stall), 32'h0);
        chk("rst busReq", 32'(busReq), 32'h0);
        chk("rst loadData", loadData, 32'h0);
        chk("rst loadValid", 32'(loadValid), 32'h0);
        step();
        busRvalid = 1;
        step();
        rstN = 1;
        busRvalid = 1;
        clearCounts();
        idle(2);
        access(1, 0, 3'b010, 32'h10, 32'hCAFEF00D, 0, 1, 0);
        settle();
        chk("postRst noLoadValid", 32'(lvCnt), 32'd0);
        chk("postRst sw addr", seenAddr, 32'h10);
        chk("postRst sw wdata", seenWdata, 32'hCAFEF00D);

        for (int n = 0; n < 300; n++) begin
            int op = $urandom % 3;
            access(op != 0, op != 1, 3'($urandom), $urandom, $urandom,
                   $urandom % 10, 1 + $urandom % 5, $urandom);
            idle($urandom % 3);
        end
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
